cache_setassoc_l2: RTL and testbench
====================================

// Module: cache_setassoc_l2
// PURPOSE
// Parametrised read-only L2 cache: N-way set-associative, true-LRU replacement, one word per line.
// Successor to the direct-mapped L2. Adds a backing-memory miss handshake, flush-all and saturating hit/miss counters.
// Sits between the L1/trace driver (read/addr) and a variable-latency backing memory.
// PARAMETERS
// ADDR_W  11  word-address width; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]
// DATA_W  11  data word width
// SETS    16  number of sets, power of 2; IDX_W = $clog2(SETS)
// WAYS    2   associativity, one of 1/2/4; AGE_W = max(1,$clog2(WAYS))
// CNT_W   16  width of hit_count/miss_count
// PORTS
// clk         in   1       single clock, rising edge
// rst         in   1       synchronous, active-high reset
// read        in   1       read request, accepted when read && ready
// addr        in   ADDR_W  request word address, sampled on acceptance
// flush       in   1       invalidate all lines, sampled only when ready
// ready       out  1       idle, can accept read/flush
// resp_valid  out  1       1-cycle pulse: read_data/hit valid
// read_data   out  DATA_W  returned word
// hit         out  1       1 = served from cache on this resp_valid
// mem_req     out  1       backing-memory request, held until mem_ready
// mem_addr    out  ADDR_W  miss address, stable while mem_req=1
// mem_ready   in   1       memory handshake done; mem_rdata valid same cycle
// mem_rdata   in   DATA_W  fill data
// hit_count   out  CNT_W   saturating hit counter
// miss_count  out  CNT_W   saturating miss counter
// BEHAVIOUR
// - Reset (rst=1 at posedge):
//   - all valid bits 0; age[set][w]=w; counters 0; state IDLE.
//   - resp_valid, hit, mem_req, read_data, mem_addr all 0; ready=0 while rst is high.
// - FSM IDLE -> LOOKUP -> (IDLE | MISS_WAIT -> FILL -> IDLE). ready = (state==IDLE) && !rst.
// - IDLE: flush has priority over read.
//   - flush=1: clear all valid bits at that edge; stay IDLE; no response.
//   - else read=1: latch addr; go to LOOKUP.
// - LOOKUP: compare the latched tag against all valid ways of the set.
//   - Hit: resp_valid=1, hit=1, read_data=way data (1 cycle after acceptance); update LRU; hit_count++; go to IDLE.
//   - Miss: miss_count++; go to MISS_WAIT with mem_req=1, mem_addr=latched addr from the next cycle.
// - MISS_WAIT: hold mem_req/mem_addr. On mem_ready=1, capture mem_rdata; mem_req=0 next cycle; go to FILL.
// - FILL: write tag/data/valid into the victim way; resp_valid=1, hit=0, read_data=captured word; update LRU; go to IDLE.
// - Victim: lowest-index invalid way, else the way with age==WAYS-1.
// - LRU update: accessed way age=0; each other way with age < old age increments. Ages stay a permutation of 0..WAYS-1.
// - WAYS=1: age logic is constant, victim is always way 0.
// - Counters saturate at 2^CNT_W-1, no wrap.
// - read/flush while ready=0 are ignored (not queued). mem_ready outside MISS_WAIT is ignored.
// - rst mid-miss: abort with no fill, no response; mem_req=0 after that edge; line contents invalidated by reset.
// - Back-to-back: a new read is accepted on the cycle resp_valid is high, since state is IDLE on the next edge.
// STRUCTURE
// - Package cache_pkg: state enum (IDLE, LOOKUP, MISS_WAIT, FILL) and the index/tag split.
// - Tag/valid/data/age arrays are flops, so flush completes in one cycle.
// - Sub-module cache_lru_age: per-set age vector plus accessed way -> next ages and victim way; purely combinational.
// TESTING
// All cases use SETS=16, WAYS=2. Addr 50: idx 2, tag 3. Addr 82: idx 2, tag 5. Addr 114: idx 2, tag 7.
// 1 Cold miss then hit.
//   - Read 50 -> mem_req=1, mem_addr=50. Drive mem_ready with 0x1A5 -> resp hit=0, data 0x1A5, miss_count=1.
//   - Read 50 again -> resp 1 cycle after acceptance with hit=1, data 0x1A5, hit_count=1.
// 2 LRU eviction.
//   - Read 50, 82, 50, then 114 -> 114 evicts 82.
//   - Read 50 -> hit=1. Read 82 -> hit=0 and mem_req=1.
// 3 Flush.
//   - Fill 50 and 82, pulse flush one cycle while ready=1.
//   - Read 50 -> hit=0; miss_count increments.
// 4 Slow memory.
//   - mem_ready arrives 5 cycles late -> mem_req/mem_addr stable throughout, ready=0.
//   - Reads pulsed during the wait -> no extra responses or count changes.
// 5 Reset mid-miss.
//   - Assert rst in MISS_WAIT -> next cycle mem_req=0, no resp_valid, counters 0.
//   - Read 50 -> miss.
// 6 Counter saturation.
//   - CNT_W=4: 1 miss then 20 hits to 50 -> hit_count=15, miss_count=1.

Source files
------------

// File: rtl/cache_setassoc_l2_pkg.sv
// Shared types and width helpers for the set-associative L2 cache.
// The FSM state enum and the index/tag split widths live here.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_WAIT = 2'd2,
        FILL      = 2'd3
    } state_t;

    function automatic int age_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_setassoc_l2_if.sv
// Request/response and backing-memory bus of the L2 cache.
// The slave modport is the cache side; master is the driver/memory side.
interface cache_setassoc_l2_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 11,
    parameter int CNT_W  = 16
);
    logic              read;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic              ready;
    logic              resp_valid;
    logic [DATA_W-1:0] read_data;
    logic              hit;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport slave (
        input  read, addr, flush, mem_ready, mem_rdata,
        output ready, resp_valid, read_data, hit, mem_req, mem_addr,
               hit_count, miss_count
    );

    modport master (
        output read, addr, flush, mem_ready, mem_rdata,
        input  ready, resp_valid, read_data, hit, mem_req, mem_addr,
               hit_count, miss_count
    );
endinterface

// File: rtl/cache_setassoc_l2_lru_age.sv
// True-LRU helper: from one set's age vector and valid bits, computes the
// victim way and the ages after an access. Purely combinational.
module cache_lru_age
    import cache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int AGE_W = age_width(WAYS)
) (
    input  logic [AGE_W-1:0] i_age [WAYS],
    input  logic [WAYS-1:0]  i_valid,
    input  logic [AGE_W-1:0] i_acc_way,
    output logic [AGE_W-1:0] o_age_next [WAYS],
    output logic [AGE_W-1:0] o_victim
);

    logic             w_found;
    logic [AGE_W-1:0] w_old_age;

    always_comb begin
        o_victim = '0;
        w_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!i_valid[w] && !w_found) begin
                o_victim = AGE_W'(w);
                w_found  = 1'b1;
            end
        end
        if (!w_found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (i_age[w] == AGE_W'(WAYS - 1))
                    o_victim = AGE_W'(w);
            end
        end
    end

    // Ways younger than the accessed one age by one; the accessed way becomes 0.
    always_comb begin
        w_old_age = i_age[i_acc_way];
        for (int w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == i_acc_way)
                o_age_next[w] = '0;
            else if (i_age[w] < w_old_age)
                o_age_next[w] = i_age[w] + 1'b1;
            else
                o_age_next[w] = i_age[w];
        end
    end

endmodule

// File: rtl/cache_setassoc_l2.sv
// Read-only N-way set-associative L2 with true-LRU, flush-all, a
// backing-memory miss handshake and saturating hit/miss counters.
module cache_setassoc_l2
    import cache_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 11,
    parameter int SETS   = 16,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    cache_setassoc_l2_if.slave  bus
);

    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS);
    localparam int AGE_W = age_width(WAYS);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [AGE_W-1:0]  r_age   [SETS][WAYS];
    logic [DATA_W-1:0] r_fill_data;
    logic              r_resp_valid;
    logic              r_hit;
    logic [DATA_W-1:0] r_read_data;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_miss_cnt;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WAYS-1:0]   w_hit_vec;
    logic              w_hit;
    logic [AGE_W-1:0]  w_hit_way;
    logic [AGE_W-1:0]  w_victim;
    logic [AGE_W-1:0]  w_acc_way;
    logic [AGE_W-1:0]  w_set_age  [WAYS];
    logic [AGE_W-1:0]  w_age_next [WAYS];

    assign w_idx = r_addr[IDX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:IDX_W];

    always_comb begin
        w_hit_vec = '0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
            w_set_age[w] = r_age[w_idx][w];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w])
                w_hit_way = AGE_W'(w);
        end
    end

    assign w_hit     = |w_hit_vec;
    assign w_acc_way = (r_state == LOOKUP) ? w_hit_way : w_victim;

    cache_lru_age #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .i_age      (w_set_age),
        .i_valid    (r_valid[w_idx]),
        .i_acc_way  (w_acc_way),
        .o_age_next (w_age_next),
        .o_victim   (w_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_fill_data  <= '0;
            r_resp_valid <= 1'b0;
            r_hit        <= 1'b0;
            r_read_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= AGE_W'(w);
            end
        end else begin
            r_resp_valid <= 1'b0;
            r_hit        <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.flush) begin
                        for (int s = 0; s < SETS; s++)
                            r_valid[s] <= '0;
                    end else if (bus.read) begin
                        r_addr  <= bus.addr;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_hit        <= 1'b1;
                        r_read_data  <= r_data[w_idx][w_hit_way];
                        for (int w = 0; w < WAYS; w++)
                            r_age[w_idx][w] <= w_age_next[w];
                        if (r_hit_cnt != '1)
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        r_state <= IDLE;
                    end else begin
                        if (r_miss_cnt != '1)
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_state    <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (bus.mem_ready) begin
                        r_fill_data <= bus.mem_rdata;
                        r_mem_req   <= 1'b0;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    r_valid[w_idx][w_victim] <= 1'b1;
                    r_tag[w_idx][w_victim]   <= w_tag;
                    r_data[w_idx][w_victim]  <= r_fill_data;
                    for (int w = 0; w < WAYS; w++)
                        r_age[w_idx][w] <= w_age_next[w];
                    r_resp_valid <= 1'b1;
                    r_read_data  <= r_fill_data;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready      = (r_state == IDLE) && !rst;
    assign bus.resp_valid = r_resp_valid;
    assign bus.hit        = r_hit;
    assign bus.read_data  = r_read_data;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;

endmodule

// File: tb/tb_cache_setassoc_l2.sv
// Scoreboard bench for cache_setassoc_l2: directed reads, fills, flush,
// slow memory, reset mid-miss and counter saturation (second, 4-bit-counter instance).
module tb_cache_setassoc_l2;

    typedef struct {
        logic        hit;
        logic [10:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cache_setassoc_l2_if #(.ADDR_W(11), .DATA_W(11), .CNT_W(16)) if0 ();
    cache_setassoc_l2_if #(.ADDR_W(11), .DATA_W(11), .CNT_W(4))  if1 ();

    assign if1.read      = if0.read;
    assign if1.addr      = if0.addr;
    assign if1.flush     = if0.flush;
    assign if1.mem_ready = if0.mem_ready;
    assign if1.mem_rdata = if0.mem_rdata;

    cache_setassoc_l2 #(.ADDR_W(11), .DATA_W(11), .SETS(16), .WAYS(2), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    cache_setassoc_l2 #(.ADDR_W(11), .DATA_W(11), .SETS(16), .WAYS(2), .CNT_W(4)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: every response must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (if0.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_resp");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_hit", {31'd0, if0.hit}, {31'd0, e.hit});
                    check("resp_data", {21'd0, if0.read_data}, {21'd0, e.data});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic expect_resp(input logic h, input logic [10:0] d);
        exp_t e;
        e.hit  = h;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_read(input logic [10:0] a);
        int n = 0;
        @(negedge clk);
        while (if0.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("read_ready");
        if0.read = 1'b1;
        if0.addr = a;
        @(negedge clk);
        if0.read = 1'b0;
    endtask

    task automatic wait_mem_req();
        int n = 0;
        while (if0.mem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("mem_req");
    endtask

    task automatic serve_mem(input logic [10:0] a, input logic [10:0] d, input int delay, input bit poke);
        wait_mem_req();
        check("mem_addr", {21'd0, if0.mem_addr}, {21'd0, a});
        check("ready_in_miss", {31'd0, if0.ready}, 32'd0);
        for (int i = 0; i < delay; i++) begin
            if (poke) begin
                if0.read = 1'b1;
                if0.addr = 11'd82;
            end
            @(negedge clk);
            if0.read = 1'b0;
            check("mem_req_hold", {31'd0, if0.mem_req}, 32'd1);
            check("mem_addr_hold", {21'd0, if0.mem_addr}, {21'd0, a});
            check("ready_hold", {31'd0, if0.ready}, 32'd0);
        end
        if0.mem_ready = 1'b1;
        if0.mem_rdata = d;
        @(negedge clk);
        if0.mem_ready = 1'b0;
        if0.mem_rdata = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(if0.ready === 1'b1 && exp_q.size() == 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("wait_done");
    endtask

    task automatic miss(input logic [10:0] a, input logic [10:0] d, input int delay, input bit poke);
        expect_resp(1'b0, d);
        do_read(a);
        serve_mem(a, d, delay, poke);
        wait_done();
    endtask

    task automatic hit_read(input logic [10:0] a, input logic [10:0] d);
        expect_resp(1'b1, d);
        do_read(a);
        wait_done();
    endtask

    task automatic check_counts(input string name, input int h, input int m);
        check({name, "_hits"}, {16'd0, if0.hit_count}, h);
        check({name, "_misses"}, {16'd0, if0.miss_count}, m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if0.read = 1'b0;
        if0.flush = 1'b0;
        if0.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, if0.ready}, 32'd0);
        check("rst_mem_req", {31'd0, if0.mem_req}, 32'd0);
        check_counts("rst", 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        if0.read      = 1'b0;
        if0.addr      = '0;
        if0.flush     = 1'b0;
        if0.mem_ready = 1'b0;
        if0.mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {31'd0, if0.resp_valid}, 32'd0);
        check("rst_hit", {31'd0, if0.hit}, 32'd0);
        check("rst_read_data", {21'd0, if0.read_data}, 32'd0);
        check("rst_mem_addr", {21'd0, if0.mem_addr}, 32'd0);
        do_reset();
        @(negedge clk);
        check("ready_after_rst", {31'd0, if0.ready}, 32'd1);

        // 1: cold miss, then hit one cycle after acceptance
        miss(11'd50, 11'h1A5, 0, 1'b0);
        check_counts("t1_miss", 0, 1);
        expect_resp(1'b1, 11'h1A5);
        do_read(11'd50);
        @(posedge clk);
        #1;
        check("hit_latency", {31'd0, if0.resp_valid}, 32'd1);
        wait_done();
        check_counts("t1_hit", 1, 1);

        // 2: LRU eviction of 82 by 114 in set 2
        do_reset();
        miss(11'd50, 11'h150, 0, 1'b0);
        miss(11'd82, 11'h252, 0, 1'b0);
        hit_read(11'd50, 11'h150);
        miss(11'd114, 11'h372, 0, 1'b0);
        hit_read(11'd50, 11'h150);
        miss(11'd82, 11'h253, 0, 1'b0);
        check_counts("t2", 2, 4);

        // 3: flush invalidates everything
        do_reset();
        miss(11'd50, 11'h111, 0, 1'b0);
        miss(11'd82, 11'h222, 0, 1'b0);
        @(negedge clk);
        if0.flush = 1'b1;
        @(negedge clk);
        if0.flush = 1'b0;
        miss(11'd50, 11'h333, 0, 1'b0);
        check_counts("t3", 0, 3);

        // 4: slow memory with reads poked during the wait; stray mem_ready when idle
        do_reset();
        miss(11'd50, 11'h0F0, 5, 1'b1);
        check_counts("t4_miss", 0, 1);
        @(negedge clk);
        if0.mem_ready = 1'b1;
        if0.mem_rdata = 11'h7FF;
        @(negedge clk);
        if0.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        hit_read(11'd50, 11'h0F0);
        check_counts("t4_hit", 1, 1);

        // 5: reset in the middle of a miss
        do_reset();
        do_read(11'd50);
        wait_mem_req();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_mem_req", {31'd0, if0.mem_req}, 32'd0);
        check("t5_resp_valid", {31'd0, if0.resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_counts("t5_abort", 0, 0);
        repeat (5) @(negedge clk);
        miss(11'd50, 11'h2AA, 0, 1'b0);
        check_counts("t5_after", 0, 1);

        // 6: 4-bit counters saturate at 15
        do_reset();
        miss(11'd50, 11'h1A5, 0, 1'b0);
        for (int i = 0; i < 20; i++)
            hit_read(11'd50, 11'h1A5);
        check_counts("t6_wide", 20, 1);
        check("t6_sat_hits", {28'd0, if1.hit_count}, 32'd15);
        check("t6_sat_misses", {28'd0, if1.miss_count}, 32'd1);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
